pcpi_div_arbiter: RTL and testbench
===================================

Name: pcpi_div_arbiter

Overview:
- Shares one PCPI divider unit (DIV/DIVU/REM/REMU, ~36-cycle iterative) between NREQ PCPI requesters, e.g. two cores, or a core plus an accelerator.
- Decodes each requester's instruction, arbitrates round-robin and latches the granted operands.
- Sequences the divider's valid/ready handshake, then routes the result back to the winning requester.
- Sits between the requesters' PCPI ports and the single divider instance.

Parameters:
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 64, watchdog limit in cycles from issue to div_ready (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester pcpi_valid
- req_insn  in  32*NREQ  per-requester instruction; requester i occupies bits [32*i+31:32*i]
- req_rs1  in  32*NREQ  per-requester operand 1
- req_rs2  in  32*NREQ  per-requester operand 2
- req_wr  out  NREQ  per-requester pcpi_wr
- req_rd  out  32*NREQ  per-requester result
- req_wait  out  NREQ  per-requester pcpi_wait
- req_ready  out  NREQ  per-requester pcpi_ready
- div_valid  out  1  to divider pcpi_valid
- div_insn  out  32  to divider pcpi_insn
- div_rs1  out  32  to divider pcpi_rs1
- div_rs2  out  32  to divider pcpi_rs2
- div_wr  in  1  from divider
- div_rd  in  32  from divider
- div_wait  in  1  from divider (monitor only)
- div_ready  in  1  from divider

Behaviour:
- Reset (async): all outputs 0; state IDLE; rr pointer = NREQ-1 (requester 0 has first priority); latched insn/rs1/rs2 = 0. The divider's resetn must be driven from !reset by the integrator.
- Eligibility: requester i is eligible when req_valid[i]=1, insn[6:0]=7'b0110011, insn[31:25]=7'b0000001 and insn[14]=1. Non-divide instructions are never granted and never get req_wait.
- req_wait[i]: registered. High one cycle after i becomes eligible, and held while i is queued or granted. Drops in the same cycle req_ready[i] rises. This stops the core's 16-cycle PCPI timeout from firing while i is queued.
- IDLE: if any requester is eligible, grant the first one found scanning from ptr+1 upward with wrap. Latch its insn/rs1/rs2, set ptr=grant, go to ISSUE. If none is eligible, stay in IDLE.
- ISSUE: div_valid=1 with the latched values. Operands are stable for the whole operation regardless of requester changes. Stay until div_ready=1.
- On the edge sampling div_ready=1:
  - div_valid goes to 0 and the divider output is captured.
  - In the next cycle (state RESP): req_ready[g]=1, req_wr[g]=div_wr, req_rd[g]=div_rd.
  - All other req_rd lanes are 0, and req_rd[g]=0 outside RESP.
- RESP lasts one cycle, then GUARD.
- GUARD lasts one cycle. Requester g is masked from eligibility during this cycle and the next arbitration, because its valid falls one cycle after ready. Then go to IDLE, where arbitration runs the same cycle.
- Latency overhead versus a direct connection: +1 cycle at issue, +1 at return, +1 GUARD between back-to-back operations.
- Simultaneous events:
  - If a requester drops req_valid while queued, it is simply not granted.
  - If the granted requester drops req_valid mid-operation, the operation completes and the result is still pulsed, and ignored.
  - A new request arriving during ISSUE/RESP/GUARD is queued.
  - If div_ready arrives in the first ISSUE cycle, it is accepted normally.
- Fairness: each eligible requester is served within NREQ-1 other operations.
- Reset during an operation: everything aborts immediately; no ready pulse is produced.

Optional Feature:
- Macro PCPI_DIV_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE.
  - If TIMEOUT cycles pass without div_ready: div_valid=0, and in RESP req_ready[g]=1, req_wr[g]=0, req_rd[g]=0.
  - Then GUARD → IDLE, and sticky output timeout_flag (1 bit, port added) is set; it clears only on reset.
- Undefined: no counter, no timeout_flag port; ISSUE waits indefinitely.

Test Plan:
- Single requester 0, DIVU rs1=100 rs2=7 → div_valid the cycle after req_valid; req_ready[0] pulse with req_wr[0]=1, req_rd[0]=14; req_wait[0] high from cycle+1 until ready.
- Requesters 0 and 1 assert in the same cycle: 0 = REM rs1=0xFFFFFFF9 (−7) rs2=2; 1 = DIV rs1=20 rs2=0xFFFFFFFC (−4) → 0 served first, rd=0xFFFFFFFF; then 1 after GUARD, rd=0xFFFFFFFB (−5); req_wait[1] held high throughout.
- Requester 0 issues MUL (funct3=000) → no grant, div_valid=0, req_wait[0]=0 permanently.
- Both requesters continuously re-request DIVU 9/3 → grants alternate 0,1,0,1; every result is 3.
- Assert reset mid-ISSUE → all outputs 0 immediately; after release, a new DIVU 1/1 returns 1.
- With PCPI_DIV_ARB_TIMEOUT_EN and a stub divider that never readies, TIMEOUT=64 → req_ready[0] pulses with req_wr[0]=0 exactly 64 cycles after issue, and timeout_flag=1.

Source files
------------

// File: rtl/pcpi_div_arbiter.sv
// Round-robin arbiter sharing one iterative PCPI divider between NREQ PCPI requesters.
// Optional watchdog (adds timeout_flag output): define PCPI_DIV_ARB_TIMEOUT_EN.
module pcpi_div_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_insn,
  input  logic [32*NREQ-1:0] req_rs1,
  input  logic [32*NREQ-1:0] req_rs2,
  output logic [NREQ-1:0]    req_wr,
  output logic [32*NREQ-1:0] req_rd,
  output logic [NREQ-1:0]    req_wait,
  output logic [NREQ-1:0]    req_ready,
  output logic               div_valid,
  output logic [31:0]        div_insn,
  output logic [31:0]        div_rs1,
  output logic [31:0]        div_rs2,
  input  logic               div_wr,
  input  logic [31:0]        div_rd,
  input  logic               div_wait,
  input  logic               div_ready
`ifdef PCPI_DIV_ARB_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GUARD} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic            gnt_found;
  logic            after_guard;
  logic            mask_on;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] elig_m;
  logic [NREQ-1:0] wait_nxt;
  logic [31:0]     insn_q, rs1_q, rs2_q;
  logic [31:0]     res_rd;
  logic            res_wr;
  logic            issue_done;
  logic            timeout_hit;
  logic            unused_div_wait;

  assign unused_div_wait = div_wait;

  // The last winner stays masked through RESP, GUARD and the following
  // arbitration: its pcpi_valid lingers one cycle past the ready pulse.
  assign mask_on = (state == RESP) || (state == GUARD) || after_guard;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i]   = req_valid[i]
                  && (req_insn[32*i +: 7] == 7'b0110011)
                  && (req_insn[32*i+25 +: 7] == 7'b0000001)
                  && req_insn[32*i+14];
      elig_m[i] = elig[i] && !(mask_on && (ptr == IW'(i)));
    end
  end

  // Round-robin scan starting just after the previous winner, with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ-1)) ? '0 : cand + 1'b1;
      if (!gnt_found && elig_m[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

`ifdef PCPI_DIV_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign timeout_hit = (state == ISSUE) && !div_ready && (wd_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wd_cnt <= (state == ISSUE) ? wd_cnt + 32'd1 : '0;
      if (timeout_hit)
        timeout_flag <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  assign issue_done = (state == ISSUE) && (div_ready || timeout_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = RESP;
      RESP:    state_nxt = GUARD;
      GUARD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait is raised for queued or granted requesters and dropped so that it
  // falls in the same cycle the ready pulse rises.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wait_nxt[i] = elig_m[i] || ((state == ISSUE) && (ptr == IW'(i)));
      if (issue_done && (ptr == IW'(i)))
        wait_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= IW'(NREQ-1);
      after_guard <= 1'b0;
      req_wait    <= '0;
    end else begin
      after_guard <= (state == GUARD);
      req_wait    <= wait_nxt;
      if ((state == IDLE) && gnt_found)
        ptr <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insn_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      res_wr <= 1'b0;
      res_rd <= '0;
    end else begin
      if ((state == IDLE) && gnt_found) begin
        for (int i = 0; i < NREQ; i++) begin
          if (gnt_idx == IW'(i)) begin
            insn_q <= req_insn[32*i +: 32];
            rs1_q  <= req_rs1[32*i +: 32];
            rs2_q  <= req_rs2[32*i +: 32];
          end
        end
      end
      if (issue_done) begin
        res_wr <= div_ready ? div_wr : 1'b0;
        res_rd <= div_ready ? div_rd : 32'd0;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    req_wr    = '0;
    req_rd    = '0;
    div_valid = (state == ISSUE);
    if (state == RESP) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ptr == IW'(i)) begin
          req_ready[i]        = 1'b1;
          req_wr[i]           = res_wr;
          req_rd[32*i +: 32]  = res_rd;
        end
      end
    end
  end

  assign div_insn = insn_q;
  assign div_rs1  = rs1_q;
  assign div_rs2  = rs2_q;

endmodule

// File: tb/tb_pcpi_div_arbiter.sv
// Bench for pcpi_div_arbiter: directed scenarios plus randomized requesters against a
// transaction-level RISC-V divide model, with a behavioural divider stub of random latency.
module tb_pcpi_div_arbiter;

  localparam int NREQ = 3;
  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] F7_M = 7'b0000001;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_insn, req_rs1, req_rs2;
  logic [NREQ-1:0]    req_wr, req_wait, req_ready;
  logic [32*NREQ-1:0] req_rd;
  logic               div_valid;
  logic [31:0]        div_insn, div_rs1, div_rs2;
  logic               div_wr;
  logic [31:0]        div_rd;
  logic               div_wait;
  logic               div_ready;
`ifdef PCPI_DIV_ARB_TIMEOUT_EN
  logic               timeout_flag;
`endif

  logic        v[NREQ];
  logic [31:0] ins[NREQ], a_in[NREQ], b_in[NREQ];

  int n_checks = 0;
  int n_errors = 0;
  int total_done = 0;
  int lat_cnt = 0;
  int lat_max = 3;
  int order_q[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = v[i];
      req_insn[32*i +: 32] = ins[i];
      req_rs1[32*i +: 32]  = a_in[i];
      req_rs2[32*i +: 32]  = b_in[i];
    end
  end

  pcpi_div_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_insn  (req_insn),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_wr    (req_wr),
    .req_rd    (req_rd),
    .req_wait  (req_wait),
    .req_ready (req_ready),
    .div_valid (div_valid),
    .div_insn  (div_insn),
    .div_rs1   (div_rs1),
    .div_rs2   (div_rs2),
    .div_wr    (div_wr),
    .div_rd    (div_rd),
    .div_wait  (div_wait),
    .div_ready (div_ready)
`ifdef PCPI_DIV_ARB_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension divide/remainder semantics.
  function automatic logic [31:0] ref_div(input logic [31:0] insn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (insn[13:12])
      2'b00:   return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP};
  endfunction

  // Divider stub: answers after a random number of cycles with valid held.
  initial begin
    div_ready = 1'b0;
    div_wr    = 1'b0;
    div_rd    = '0;
    div_wait  = 1'b0;
    forever begin
      @(negedge clk);
      if (div_ready) begin
        div_ready = 1'b0;
        div_wr    = 1'b0;
        div_rd    = '0;
      end else if (div_valid) begin
        if (lat_cnt <= 0) begin
          div_ready = 1'b1;
          div_wr    = 1'b1;
          div_rd    = ref_div(div_insn, div_rs1, div_rs2);
          lat_cnt   = $urandom_range(lat_max, 0);
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  always @(posedge clk) if (|req_ready) total_done <= total_done + 1;

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 1);
      for (int i = 0; i < NREQ; i++)
        if (!req_ready[i]) chk("rd_idle_zero", req_rd[32*i +: 32], 0);
    end
  end

  task automatic drive(input int i, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b);
    ins[i]  = insn;
    a_in[i] = a;
    b_in[i] = b;
    v[i]    = 1'b1;
  endtask

  // Wait for requester i's result, checking wait, result and fairness bound.
  task automatic serve(input int i, input logic [31:0] exp_rd);
    int snap;
    bit got;
    got  = 1'b0;
    snap = total_done + ((|req_ready) ? 1 : 0);
    for (int n = 0; n < 600 && !got; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        order_q.push_back(i);
        chk("resp_wr", req_wr[i], 1);
        chk("resp_rd", req_rd[32*i +: 32], exp_rd);
        chk("wait_drop", req_wait[i], 0);
        chk("fairness", 64'((total_done - snap) <= NREQ - 1), 1);
      end else begin
        chk("wait_hold", req_wait[i], 1);
      end
    end
    chk("ready_seen", got, 1);
    @(negedge clk);
    v[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rep_core(input int i);
    repeat (3) begin
      drive(i, mk(F7_M, 3'b101), 9, 3);
      serve(i, 32'd3);
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic rand_core(input int i, input int nops);
    logic [31:0] insn, a, b;
    for (int n = 0; n < nops; n++) begin
      repeat ($urandom_range(4, 2)) @(negedge clk);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7, 0))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = $urandom_range(1000, 0); b = $urandom_range(20, 1); end
        default: ;
      endcase
      if ($urandom_range(9, 0) == 0) begin
        insn = ($urandom_range(1, 0) == 1) ? mk(F7_M, 3'($urandom_range(3, 0)))
                                           : mk(7'b0000000, 3'b100);
        drive(i, insn, a, b);
        repeat (6) begin
          @(negedge clk);
          chk("nondiv_quiet", {req_wait[i], req_ready[i]}, 0);
        end
        v[i] = 1'b0;
      end else begin
        insn = mk(F7_M, 3'(4 + $urandom_range(3, 0)));
        drive(i, insn, a, b);
        serve(i, ref_div(insn, a, b));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; ins[i] = '0; a_in[i] = '0; b_in[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_div_valid", div_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wait", req_wait, 0);
    chk("rst_wr", req_wr, 0);
    chk("rst_div_ops", {div_rs1, div_rs2}, 0);
    chk("rst_div_insn", div_insn, 0);
    for (int i = 0; i < NREQ; i++) chk("rst_rd", req_rd[32*i +: 32], 0);
    reset = 1'b0;

    // single DIVU 100/7
    drive(0, mk(F7_M, 3'b101), 100, 7);
    fork
      serve(0, 32'd14);
      begin @(negedge clk); chk("t1_issue_latency", div_valid, 1); end
    join

    // simultaneous requests: 0 first, 1 after GUARD
    do_reset();
    drive(0, mk(F7_M, 3'b110), 32'hFFFFFFF9, 32'd2);
    drive(1, mk(F7_M, 3'b100), 32'd20, 32'hFFFFFFFC);
    order_q.delete();
    fork
      serve(0, 32'hFFFFFFFF);
      serve(1, 32'hFFFFFFFB);
    join
    chk("t2_first", order_q.size() > 0 ? order_q[0] : -1, 0);

    // MUL is never granted
    do_reset();
    drive(0, mk(F7_M, 3'b000), 32'd3, 32'd4);
    repeat (20) begin
      @(negedge clk);
      chk("t3_mul_quiet", {div_valid, req_wait[0], req_ready[0]}, 0);
    end
    v[0] = 1'b0;

    // continuous re-requests alternate
    do_reset();
    order_q.delete();
    fork
      rep_core(0);
      rep_core(1);
    join
    chk("t4_count", order_q.size(), 6);
    for (int n = 0; n < order_q.size() && n < 6; n++) chk("t4_order", order_q[n], n % 2);

    // reset mid-ISSUE
    do_reset();
    lat_cnt = 100000;
    drive(0, mk(F7_M, 3'b101), 32'd5, 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_in_issue", div_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_abort_valid", div_valid, 0);
    chk("t5_abort_wait", req_wait, 0);
    chk("t5_abort_ready", req_ready, 0);
    chk("t5_abort_ops", {div_rs1, div_rs2}, 0);
    v[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    lat_cnt = 1;
    @(negedge clk);
    drive(0, mk(F7_M, 3'b101), 32'd1, 32'd1);
    serve(0, 32'd1);

    // randomized traffic from all requesters
    do_reset();
    lat_max = 5;
    fork
      rand_core(0, 25);
      rand_core(1, 25);
      rand_core(2, 25);
    join
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
